// File: rtl/mem_stage.sv
// Memory stage: data-memory handshake with timeout, branch/jump resolution,
// MEM/WB pipeline register and forwarding results.
module mem_stage #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned IMM8_WIDTH = 8,
   parameter int unsigned REG_WIDTH  = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] PCM_i,
   input  logic [DATA_WIDTH-1:0] WriteDataM_i,
   input  logic [IMM8_WIDTH-1:0] imm8M_i,
   input  logic [REG_WIDTH-1:0]  WriteRegM_i,
   input  logic [DATA_WIDTH-1:0] alu_outM_i,
   input  logic                  RegWriteM_i,
   input  logic                  BranchM_i,
   input  logic                  MemReadM_i,
   input  logic                  MemWriteM_i,
   input  logic                  MemToRegM_i,
   input  logic                  MovM_i,
   input  logic                  jumpM_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
   input  logic                  dmem_ready_i,
   output logic                  stall_mem_o,
   output logic                  pc_src_o,
   output logic [ADDR_WIDTH-1:0] pc_target_o,
   output logic [DATA_WIDTH-1:0] WBResultM_o,
   output logic                  RegWriteW_o,
   output logic                  MemToRegW_o,
   output logic [REG_WIDTH-1:0]  WriteRegW_o,
   output logic [DATA_WIDTH-1:0] ReadDataW_o,
   output logic [DATA_WIDTH-1:0] alu_outW_o,
   output logic [DATA_WIDTH-1:0] ResultW_o,
   output logic                  mem_err_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic          mem_op;
   logic          abort;
   logic          taken;

   always_comb begin
      mem_op = MemReadM_i | MemWriteM_i;
      abort  = (state == WAIT) && !dmem_ready_i && (cnt == CW'(TIMEOUT));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mem_op && !dmem_ready_i) state_next = WAIT;
         WAIT:    if (dmem_ready_i || abort)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      dmem_req_o   = mem_op;
      dmem_we_o    = MemWriteM_i;
      dmem_addr_o  = alu_outM_i[ADDR_WIDTH-1:0];
      dmem_wdata_o = WriteDataM_i;
      stall_mem_o  = mem_op && !(dmem_ready_i || abort);
      taken        = BranchM_i && (alu_outM_i == '0);
      pc_src_o     = (taken || jumpM_i) && !stall_mem_o;
      pc_target_o  = jumpM_i ? ADDR_WIDTH'(imm8M_i) : PCM_i + ADDR_WIDTH'(imm8M_i);
      WBResultM_o  = MovM_i ? DATA_WIDTH'(imm8M_i) : alu_outM_i;
      ResultW_o    = MemToRegW_o ? ReadDataW_o : alu_outW_o;
   end

   // Wait counter and sticky error; counter starts at 1 on the first waited cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         mem_err_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mem_op && !dmem_ready_i) cnt <= CW'(1);
            WAIT: begin
               if (dmem_ready_i) begin
                  cnt <= '0;
               end else if (abort) begin
                  cnt       <= '0;
                  mem_err_o <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || stall_mem_o) begin
         RegWriteW_o <= 1'b0;
         MemToRegW_o <= 1'b0;
         WriteRegW_o <= '0;
         ReadDataW_o <= '0;
         alu_outW_o  <= '0;
      end else begin
         RegWriteW_o <= RegWriteM_i;
         MemToRegW_o <= MemToRegM_i;
         WriteRegW_o <= WriteRegM_i;
         ReadDataW_o <= abort ? '0 : dmem_rdata_i;
         alu_outW_o  <= WBResultM_o;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: handshake timing, timeout, branch/jump and
// MEM/WB forwarding, checked with immediate assertions.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  PCM_i;
   logic [15:0] WriteDataM_i;
   logic [7:0]  imm8M_i;
   logic [3:0]  WriteRegM_i;
   logic [15:0] alu_outM_i;
   logic        RegWriteM_i, BranchM_i, MemReadM_i, MemWriteM_i;
   logic        MemToRegM_i, MovM_i, jumpM_i;
   logic        dmem_req_o, dmem_we_o;
   logic [7:0]  dmem_addr_o;
   logic [15:0] dmem_wdata_o, dmem_rdata_i;
   logic        dmem_ready_i;
   logic        stall_mem_o, pc_src_o;
   logic [7:0]  pc_target_o;
   logic [15:0] WBResultM_o;
   logic        RegWriteW_o, MemToRegW_o;
   logic [3:0]  WriteRegW_o;
   logic [15:0] ReadDataW_o, alu_outW_o, ResultW_o;
   logic        mem_err_o;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned nstall;

   always #5 clk = ~clk;

   mem_stage #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .IMM8_WIDTH(8), .REG_WIDTH(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .PCM_i(PCM_i), .WriteDataM_i(WriteDataM_i),
      .imm8M_i(imm8M_i), .WriteRegM_i(WriteRegM_i), .alu_outM_i(alu_outM_i),
      .RegWriteM_i(RegWriteM_i), .BranchM_i(BranchM_i), .MemReadM_i(MemReadM_i),
      .MemWriteM_i(MemWriteM_i), .MemToRegM_i(MemToRegM_i), .MovM_i(MovM_i),
      .jumpM_i(jumpM_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_rdata_i(dmem_rdata_i), .dmem_ready_i(dmem_ready_i),
      .stall_mem_o(stall_mem_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o),
      .WBResultM_o(WBResultM_o), .RegWriteW_o(RegWriteW_o), .MemToRegW_o(MemToRegW_o),
      .WriteRegW_o(WriteRegW_o), .ReadDataW_o(ReadDataW_o), .alu_outW_o(alu_outW_o),
      .ResultW_o(ResultW_o), .mem_err_o(mem_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nop();
      PCM_i = '0; WriteDataM_i = '0; imm8M_i = '0; WriteRegM_i = '0; alu_outM_i = '0;
      RegWriteM_i = 0; BranchM_i = 0; MemReadM_i = 0; MemWriteM_i = 0;
      MemToRegM_i = 0; MovM_i = 0; jumpM_i = 0;
      dmem_rdata_i = '0; dmem_ready_i = 0;
   endtask

   task automatic chk_wb(input string tag, input logic rw, input logic m2r,
                         input logic [3:0] wr, input logic [15:0] rd,
                         input logic [15:0] ao, input logic [15:0] res);
      chk({tag, "_regwrite"}, RegWriteW_o, rw);
      chk({tag, "_memtoreg"}, MemToRegW_o, m2r);
      chk({tag, "_writereg"}, WriteRegW_o, wr);
      chk({tag, "_readdata"}, ReadDataW_o, rd);
      chk({tag, "_aluout"},   alu_outW_o,  ao);
      chk({tag, "_result"},   ResultW_o,   res);
   endtask

   initial begin
      // Reset for two cycles
      rst_n = 0; nop();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_wb("reset", 0, 0, 4'h0, 16'h0, 16'h0, 16'h0);
      chk("reset_err", mem_err_o, 0);
      chk("reset_stall", stall_mem_o, 0);

      // Load, memory ready on the 3rd request cycle
      rst_n = 1;
      MemReadM_i = 1; MemToRegM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd5;
      alu_outM_i = 16'h0020;
      #1;
      chk("ld_req", dmem_req_o, 1);
      chk("ld_we", dmem_we_o, 0);
      chk("ld_addr", dmem_addr_o, 8'h20);
      chk("ld_stall_c1", stall_mem_o, 1);
      BranchM_i = 1; alu_outM_i = 16'h0000;
      #1 chk("br_blocked_by_stall", pc_src_o, 0);
      BranchM_i = 0; alu_outM_i = 16'h0020;
      @(negedge clk);
      chk("ld_stall_c2", stall_mem_o, 1);
      chk("ld_bubble_c2", RegWriteW_o, 0);
      @(negedge clk);
      chk("ld_bubble_c3", RegWriteW_o, 0);
      dmem_ready_i = 1; dmem_rdata_i = 16'hBEEF;
      #1 chk("ld_stall_c3", stall_mem_o, 0);
      @(negedge clk);
      chk_wb("ld3", 1, 1, 4'd5, 16'hBEEF, 16'h0020, 16'hBEEF);

      // Zero-wait store
      nop();
      MemWriteM_i = 1; alu_outM_i = 16'h0012; WriteDataM_i = 16'h00AA; dmem_ready_i = 1;
      #1;
      chk("st_req", dmem_req_o, 1);
      chk("st_we", dmem_we_o, 1);
      chk("st_addr", dmem_addr_o, 8'h12);
      chk("st_wdata", dmem_wdata_o, 16'h00AA);
      chk("st_stall", stall_mem_o, 0);
      MemReadM_i = 1;
      #1 chk("rdwr_is_write", dmem_we_o, 1);
      MemReadM_i = 0;
      @(negedge clk);
      chk("st_regwrite", RegWriteW_o, 0);
      chk("st_result", ResultW_o, 16'h0012);

      // Branch / jump resolution
      nop();
      BranchM_i = 1; alu_outM_i = 16'h0000; PCM_i = 8'hF8; imm8M_i = 8'h10;
      #1;
      chk("br_taken", pc_src_o, 1);
      chk("br_target_wrap", pc_target_o, 8'h08);
      alu_outM_i = 16'h0001;
      #1 chk("br_not_taken", pc_src_o, 0);
      alu_outM_i = 16'h0000; jumpM_i = 1; imm8M_i = 8'h40;
      #1;
      chk("jmp_src", pc_src_o, 1);
      chk("jmp_target", pc_target_o, 8'h40);
      dmem_ready_i = 1;
      #1 chk("ready_no_op_stall", stall_mem_o, 0);

      // Mov forwarding
      @(negedge clk);
      nop();
      MovM_i = 1; imm8M_i = 8'h7F; alu_outM_i = 16'h1234; RegWriteM_i = 1; WriteRegM_i = 4'd3;
      #1 chk("mov_wbm", WBResultM_o, 16'h007F);
      @(negedge clk);
      chk_wb("mov", 1, 0, 4'd3, 16'h0000, 16'h007F, 16'h007F);

      // Load that never completes: timeout abort
      nop();
      MemReadM_i = 1; MemToRegM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd7;
      alu_outM_i = 16'h0030; dmem_rdata_i = 16'hDEAD;
      #1;
      nstall = 0;
      for (int i = 0; i < 40; i++) begin
         if (!stall_mem_o) break;
         nstall++;
         @(negedge clk); #1;
      end
      chk("to_stall_cycles", nstall, 15);
      chk("to_err_before_abort", mem_err_o, 0);
      @(negedge clk);
      chk("to_err", mem_err_o, 1);
      chk("to_readdata", ReadDataW_o, 16'h0000);
      chk("to_result", ResultW_o, 16'h0000);

      // Following zero-wait load, error stays sticky
      WriteRegM_i = 4'd8; dmem_ready_i = 1; dmem_rdata_i = 16'h1111;
      #1 chk("after_to_stall", stall_mem_o, 0);
      @(negedge clk);
      chk_wb("after_to", 1, 1, 4'd8, 16'h1111, 16'h0030, 16'h1111);
      chk("err_sticky", mem_err_o, 1);

      // Reset during a wait abandons the access
      dmem_ready_i = 0; WriteRegM_i = 4'd9;
      @(negedge clk);
      chk("mid_wait_bubble", RegWriteW_o, 0);
      rst_n = 0;
      @(negedge clk);
      chk("rst_mid_err", mem_err_o, 0);
      chk("rst_mid_regwrite", RegWriteW_o, 0);
      rst_n = 1; nop();
      @(negedge clk);
      chk("rst_mid_no_wb", RegWriteW_o, 0);
      MemReadM_i = 1; RegWriteM_i = 1; WriteRegM_i = 4'd2; alu_outM_i = 16'h0044;
      #1 chk("post_rst_stall", stall_mem_o, 1);
      @(negedge clk);
      dmem_ready_i = 1; dmem_rdata_i = 16'h5A5A;
      @(negedge clk);
      chk_wb("post_rst", 1, 0, 4'd2, 16'h5A5A, 16'h0044, 16'h0044);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
